// File: rtl/tone_pwm_driver.sv
// ---------------------------------------------------------------------------
// tone_pwm_driver
//
// Square-wave tone generator for a piezo buzzer. A valid tone period is
// preceded by a short articulation silence (GAP), then played as a PWM
// waveform whose duty cycle follows the live volume setting. Changing the
// tone, or strobing note_strobe, re-articulates the note: the current period
// always runs to completion, then a fresh GAP is inserted before the new
// period starts, so the output never glitches mid-period.
//
// Parameters
//   GAP_CYCLES    articulation silence between notes, in clk cycles
//   MIN_PERIOD    smallest tone_period treated as audible
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   enable         playback enable from the player path
//   tone_period    full square-wave period in clk cycles, 0 = silent
//   note_strobe    one-cycle pulse requesting re-articulation (PLAY only)
//   volume         duty select: 3 = 50 %, 2 = 25 %, 1 = 12.5 %, 0 = mute
//   buzzer         registered PWM drive to the piezo
//   playing        high while the generator is in PLAY
//   active_period  period being generated, 0 outside PLAY
// ---------------------------------------------------------------------------
module tone_pwm_driver #(
    parameter int unsigned GAP_CYCLES = 120000,
    parameter int unsigned MIN_PERIOD = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] tone_period,
    input  logic        note_strobe,
    input  logic [1:0]  volume,
    output logic        buzzer,
    output logic        playing,
    output logic [15:0] active_period
);

    // Gap counter only needs to reach GAP_CYCLES-1.
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGap  = 2'd1;
    localparam logic [1:0] StPlay = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [15:0]     pend_q, pend_d;
    logic            retrig_q, retrig_d;
    logic [15:0]     active_q, active_d;
    logic            buzzer_q, buzzer_d;
    logic            playing_q, playing_d;

    logic            tone_valid;
    logic            run_ok;
    logic            period_end;
    logic            rearticulate;
    logic [15:0]     duty;

    // -----------------------------------------------------------------------
    // Input qualification
    // -----------------------------------------------------------------------
    always_comb begin
        tone_valid   = (tone_period != 16'd0) && (32'(tone_period) >= MIN_PERIOD);
        run_ok       = enable && tone_valid;
        period_end   = (cnt_q == (active_q - 16'd1));
        // Only meaningful in PLAY; a silent tone is handled by run_ok first.
        rearticulate = (tone_period != active_q) || note_strobe;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        retrig_d = retrig_q;
        active_d = active_q;

        case (state_q)
            StIdle: begin
                if (run_ok) begin
                    pend_d  = tone_period;
                    gap_d   = '0;
                    state_d = StGap;
                end
            end

            StGap: begin
                if (!run_ok) begin
                    state_d = StIdle;
                    gap_d   = '0;
                end else if (tone_period != pend_q) begin
                    // New note arrived during the silence: restart the gap.
                    pend_d = tone_period;
                    gap_d  = '0;
                end else if (gap_q == GapLast) begin
                    state_d  = StPlay;
                    active_d = pend_q;
                    cnt_d    = 16'd0;
                    gap_d    = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            StPlay: begin
                if (!run_ok) begin
                    // Stop wins over any pending re-articulation.
                    state_d  = StIdle;
                    active_d = 16'd0;
                    cnt_d    = 16'd0;
                    retrig_d = 1'b0;
                end else begin
                    if (rearticulate) begin
                        retrig_d = 1'b1;
                        pend_d   = tone_period;
                    end
                    if (period_end) begin
                        cnt_d = 16'd0;
                        // Only a request already registered before the last
                        // cycle of the period cuts over at this boundary.
                        if (retrig_q) begin
                            state_d  = StGap;
                            gap_d    = '0;
                            retrig_d = 1'b0;
                            active_d = 16'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d  = StIdle;
                cnt_d    = 16'd0;
                gap_d    = '0;
                retrig_d = 1'b0;
                active_d = 16'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PWM output: duty follows the live volume, output lags cnt by a cycle
    // -----------------------------------------------------------------------
    always_comb begin
        case (volume)
            2'd3:    duty = active_q >> 1;
            2'd2:    duty = active_q >> 2;
            2'd1:    duty = active_q >> 3;
            default: duty = 16'd0;
        endcase
        buzzer_d  = (state_q == StPlay) && (volume != 2'd0) && (cnt_q < duty);
        playing_d = (state_d == StPlay);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            gap_q     <= '0;
            pend_q    <= 16'd0;
            retrig_q  <= 1'b0;
            active_q  <= 16'd0;
            buzzer_q  <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            pend_q    <= pend_d;
            retrig_q  <= retrig_d;
            active_q  <= active_d;
            buzzer_q  <= buzzer_d;
            playing_q <= playing_d;
        end
    end

    assign buzzer        = buzzer_q;
    assign playing       = playing_q;
    assign active_period = active_q;

endmodule

// File: doc/tone_pwm_driver.md
TONE_PWM_DRIVER -- requirements
Module: tone_pwm_driver

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 120000, meaning articulation silence between notes in clk cycles (10 ms at 12 MHz).
REQ-002 SHALL have parameter MIN_PERIOD, default 64, meaning the smallest tone_period treated as audible; smaller nonzero values are silent.
REQ-003 clk  input  1  single system clock, 12 MHz.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 enable  input  1  playback enable from the player path.
REQ-006 tone_period  input  16  full square-wave period in clk cycles; 0 = silent.
REQ-007 note_strobe  input  1  one-cycle pulse requesting re-articulation of the current note.
REQ-008 volume  input  2  duty select: 3 = 50%, 2 = 25%, 1 = 12.5%, 0 = mute.
REQ-009 buzzer  output  1  registered PWM drive to the piezo.
REQ-010 playing  output  1  high while in PLAY.
REQ-011 active_period  output  16  period currently being generated; 0 when not in PLAY.

Function
REQ-012 SHALL implement states IDLE, GAP and PLAY, with a 16-bit period counter cnt, a gap counter and a 16-bit pending_period register.
REQ-013 A tone is valid when tone_period >= MIN_PERIOD; otherwise it is silent.
REQ-014 IDLE: if enable and the tone is valid, latch pending_period = tone_period, clear the gap counter, go to GAP next cycle.
REQ-015 GAP: the gap counter increments each cycle; at GAP_CYCLES-1, go to PLAY with active_period = pending_period and cnt = 0.
REQ-016 GAP: if tone_period changes to another valid value, relatch pending_period and restart the gap counter at 0.
REQ-017 GAP: if !enable or the tone is silent, go to IDLE next cycle.
REQ-018 PLAY: cnt counts 0..active_period-1 and wraps to 0.
REQ-019 PLAY: if !enable or the tone is silent, go to IDLE next cycle and set active_period = 0; this takes priority over every other event.
REQ-020 PLAY: on a valid tone_period != active_period, or on note_strobe, set a retrigger flag and latch pending_period = tone_period.
- The flag is cleared on entering GAP.
- At cnt == active_period-1 with the flag set, go to GAP instead of wrapping; the current period always completes (glitch-free).
- A later change before the boundary overwrites pending_period.
REQ-021 duty = active_period>>1, >>2 or >>3 for volume 3, 2 or 1, using volume sampled live each cycle.
REQ-022 buzzer <= (state==PLAY) && volume!=0 && cnt < duty.
- Registered; lags cnt by one cycle.
- Low in IDLE and GAP.
REQ-023 playing SHALL be registered as (next state == PLAY), so it rises on the same edge as PLAY entry.
REQ-024 The tone is sampled every cycle; no input holding requirement exists beyond what the state rules specify.
REQ-025 note_strobe in IDLE or GAP SHALL be ignored.

Reset
REQ-026 On a clk edge with rst_n low:
- state = IDLE; cnt, gap counter, pending_period and retrigger flag = 0.
- buzzer = 0, playing = 0, active_period = 0.
- Applies regardless of current state, including mid-period or mid-gap.
REQ-027 After rst_n rises, the first valid tone SHALL follow the normal IDLE->GAP->PLAY sequence.

Verification (bench uses GAP_CYCLES=4, MIN_PERIOD=64)
REQ-028 Reset: rst_n low 2 cycles with enable=1, tone_period=100 -> buzzer=0, playing=0, active_period=0 throughout; GAP entered on the first edge after release.
REQ-029 Start: from IDLE, enable=1, volume=3, tone_period=100 -> playing rises 5 edges later, active_period=100, then buzzer repeats 50 cycles high / 50 low.
REQ-030 Change: tone_period 100->200 at cnt=30 -> 100-cycle period completes, buzzer low 4 cycles (playing=0), then period 200 at 50% (100 high).
REQ-031 Volume: period 200 with volume=1 -> 25 high / 175 low; volume=0 -> buzzer constant 0 while playing=1.
REQ-032 Stop: during PLAY, tone_period=50 (below MIN_PERIOD), or enable=0, or tone_period=0 -> IDLE next edge, active_period=0, buzzer 0 within 2 cycles.
REQ-033 Repeat note: note_strobe with tone_period unchanged at 100 -> 4-cycle silent gap inserted at the period boundary, then period 100 resumes.
